fetch_decode_buffer: RTL and testbench

- Elastic FIFO between instruction fetch and decode_and_issue.
- Captures fetched instruction words, with PC, fetch status and instruction ID, from the fetch stage.
- Presents the oldest entry as the decode packet. Pops on decode_advance.
- Decouples fetch stalls from issue back-pressure. Discards all contents on a fetch flush.

---
 rtl/fetch_decode_buffer_pkg.sv | 16 +
 rtl/fetch_decode_buffer_if.sv | 35 +++
 rtl/fetch_decode_buffer_ptr.sv | 49 ++++
 rtl/fetch_decode_buffer.sv | 83 ++++++++
 tb/tb_fetch_decode_buffer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// rtl/fetch_decode_buffer_pkg.sv - shared fetch buffer types and defaults
package cva5_types;

    localparam int FETCH_BUFFER_DEPTH_DEFAULT = 4;
    localparam int FETCH_ID_W_DEFAULT         = 3;
    localparam int FETCH_ECODE_W_DEFAULT      = 5;

    typedef struct packed {
        logic [31:0]                      pc;
        logic [31:0]                      instruction;
        logic                             ok;
        logic [FETCH_ECODE_W_DEFAULT-1:0] error_code;
        logic [FETCH_ID_W_DEFAULT-1:0]    id;
    } fetch_buffer_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// rtl/fetch_decode_buffer_if.sv - fetch-side and decode-side handshake bundle
interface fetch_decode_buffer_if #(
    parameter int ID_W    = 3,
    parameter int ECODE_W = 5
);
    logic               fetch_valid;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_instruction;
    logic               fetch_ok;
    logic [ECODE_W-1:0] fetch_error_code;
    logic [ID_W-1:0]    fetch_id;
    logic               fetch_ready;

    logic               decode_valid;
    logic [31:0]        decode_pc;
    logic [31:0]        decode_instruction;
    logic               decode_ok;
    logic [ECODE_W-1:0] decode_error_code;
    logic [ID_W-1:0]    decode_id;
    logic               decode_advance;

    modport master (
        output fetch_valid, fetch_pc, fetch_instruction, fetch_ok, fetch_error_code, fetch_id,
        output decode_advance,
        input  fetch_ready,
        input  decode_valid, decode_pc, decode_instruction, decode_ok, decode_error_code, decode_id
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instruction, fetch_ok, fetch_error_code, fetch_id,
        input  decode_advance,
        output fetch_ready,
        output decode_valid, decode_pc, decode_instruction, decode_ok, decode_error_code, decode_id
    );
endinterface

// File: rtl/fetch_decode_buffer_ptr.sv
// rtl/fetch_decode_buffer_ptr.sv - wrap-bit read/write pointer and occupancy tracker
module fetch_buffer_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [$clog2(DEPTH)-1:0] wr_idx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0] wr_ptr_q, wr_ptr_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign rd_idx    = rd_ptr_q[IDX_W-1:0];
    assign wr_idx    = wr_ptr_q[IDX_W-1:0];
    assign empty     = (rd_ptr_q == wr_ptr_q);
    assign full      = (rd_idx == wr_idx) && (rd_ptr_q[IDX_W] != wr_ptr_q[IDX_W]);
    // Modular subtraction of the wrap-extended pointers yields 0..DEPTH.
    assign occupancy = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - elastic fetch-to-decode FIFO; FETCH_DECODE_BYPASS_EN adds empty bypass
module fetch_decode_buffer
    import cva5_types::*;
#(
    parameter int DEPTH   = FETCH_BUFFER_DEPTH_DEFAULT,
    parameter int ID_W    = 3,
    parameter int ECODE_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    fetch_decode_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        instruction;
        logic               ok;
        logic [ECODE_W-1:0] error_code;
        logic [ID_W-1:0]    id;
    } entry_t;

    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    entry_t wr_entry;
    entry_t head;
    entry_t out_entry;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic full, empty, push, pop, bypass_sel, bypass_take;

    assign wr_entry = '{pc: bus.fetch_pc, instruction: bus.fetch_instruction, ok: bus.fetch_ok,
                        error_code: bus.fetch_error_code, id: bus.fetch_id};
    assign head = mem_q[rd_idx];

`ifdef FETCH_DECODE_BYPASS_EN
    assign bypass_sel  = empty & bus.fetch_valid & ~flush;
    assign bypass_take = bypass_sel & bus.decode_advance;
`else
    assign bypass_sel  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    // fetch_ready comes only from the registered full flag.
    assign bus.fetch_ready = ~full;
    assign push = bus.fetch_valid & ~full & ~flush & ~bypass_take;
    assign pop  = bus.decode_advance & ~empty & ~flush;

    assign out_entry              = bypass_sel ? wr_entry : head;
    assign bus.decode_valid       = ~empty | bypass_sel;
    assign bus.decode_pc          = out_entry.pc;
    assign bus.decode_instruction = out_entry.instruction;
    assign bus.decode_ok          = out_entry.ok;
    assign bus.decode_error_code  = out_entry.error_code;
    assign bus.decode_id          = out_entry.id;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_idx] = wr_entry;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    fetch_buffer_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .rd_idx    (rd_idx),
        .wr_idx    (wr_idx),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    advance_needs_valid: assert property (@(posedge clk) disable iff (rst)
        bus.decode_advance |-> bus.decode_valid);
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb/tb_fetch_decode_buffer.sv - directed self-checking bench for fetch_decode_buffer
module tb_fetch_decode_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;
    int         total  = 0;
    int         passed = 0;

    fetch_decode_buffer_if #(.ID_W(3), .ECODE_W(5)) bus ();

    fetch_decode_buffer #(.DEPTH(4), .ID_W(3), .ECODE_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [31:0] pc, input logic ok, input logic [4:0] ec, input logic [2:0] id);
        bus.fetch_pc          = pc;
        bus.fetch_instruction = pc ^ 32'hA5A5_0000;
        bus.fetch_ok          = ok;
        bus.fetch_error_code  = ec;
        bus.fetch_id          = id;
    endtask

    task automatic push_word(input logic [31:0] pc);
        set_word(pc, 1'b1, 5'd0, pc[4:2]);
        bus.fetch_valid = 1'b1;
        step();
        bus.fetch_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.decode_advance = 1'b0;
        set_word(32'h0, 1'b1, 5'd0, 3'd0);
        step();
        step();
        rst = 1'b0;
        chk("reset_occ", 32'(occupancy), 32'd0);
        chk("reset_valid", 32'(bus.decode_valid), 32'd0);
        chk("reset_ready", 32'(bus.fetch_ready), 32'd1);

        // three pushes, no decode
        push_word(32'h1000);
        push_word(32'h1004);
        push_word(32'h1008);
        chk("fill3_occ", 32'(occupancy), 32'd3);
        chk("fill3_pc", bus.decode_pc, 32'h1000);
        chk("fill3_instr", bus.decode_instruction, 32'h1000 ^ 32'hA5A5_0000);
        chk("fill3_ready", 32'(bus.fetch_ready), 32'd1);

        // full: push refused even while popping
        push_word(32'h100C);
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_ready", 32'(bus.fetch_ready), 32'd0);
        set_word(32'h1010, 1'b1, 5'd0, 3'd4);
        bus.fetch_valid = 1'b1;
        bus.decode_advance = 1'b1;
        #1;
        chk("full_ready_pop", 32'(bus.fetch_ready), 32'd0);
        step();
        bus.fetch_valid = 1'b0;
        chk("full_pop_occ", 32'(occupancy), 32'd3);
        chk("full_pop_pc", bus.decode_pc, 32'h1004);
        step();
        chk("drain_pc_1008", bus.decode_pc, 32'h1008);
        step();
        chk("drain_pc_100c", bus.decode_pc, 32'h100C);
        step();
        bus.decode_advance = 1'b0;
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_valid", 32'(bus.decode_valid), 32'd0);

        // streaming push+pop every cycle across pointer wrap
        push_word(32'h2000);
        push_word(32'h2004);
        bus.fetch_valid = 1'b1;
        bus.decode_advance = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_word(32'h2008 + 32'(4 * k), 1'b1, 5'd0, 3'(k));
            chk("stream_pc", bus.decode_pc, 32'h2000 + 32'(4 * k));
            chk("stream_occ", 32'(occupancy), 32'd2);
            step();
        end
        bus.fetch_valid = 1'b0;
        chk("stream_tail0", bus.decode_pc, 32'h2028);
        step();
        chk("stream_tail1", bus.decode_pc, 32'h202C);
        step();
        bus.decode_advance = 1'b0;
        chk("stream_empty", 32'(occupancy), 32'd0);

        // flush beats simultaneous push and pop
        push_word(32'h4000);
        push_word(32'h4004);
        push_word(32'h4008);
        flush = 1'b1;
        set_word(32'h4100, 1'b1, 5'd0, 3'd1);
        bus.fetch_valid = 1'b1;
        bus.decode_advance = 1'b1;
        step();
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.decode_advance = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(bus.decode_valid), 32'd0);
        chk("flush_ready", 32'(bus.fetch_ready), 32'd1);
        step();
        chk("flush_hold_valid", 32'(bus.decode_valid), 32'd0);

        // latency into an empty buffer
        set_word(32'h6000, 1'b1, 5'd0, 3'd2);
        bus.fetch_valid = 1'b1;
        #1;
`ifdef FETCH_DECODE_BYPASS_EN
        chk("latency_same_cycle", 32'(bus.decode_valid), 32'd1);
`else
        chk("latency_same_cycle", 32'(bus.decode_valid), 32'd0);
`endif
        step();
        bus.fetch_valid = 1'b0;
        chk("latency_next_valid", 32'(bus.decode_valid), 32'd1);
        chk("latency_next_pc", bus.decode_pc, 32'h6000);
        bus.decode_advance = 1'b1;
        step();
        bus.decode_advance = 1'b0;

        // fault status fields carried to the head
        set_word(32'h5000, 1'b0, 5'd1, 3'd5);
        bus.fetch_valid = 1'b1;
        step();
        bus.fetch_valid = 1'b0;
        chk("fault_ok", 32'(bus.decode_ok), 32'd0);
        chk("fault_ecode", 32'(bus.decode_error_code), 32'd1);
        chk("fault_id", 32'(bus.decode_id), 32'd5);
        chk("fault_pc", bus.decode_pc, 32'h5000);

        // reset mid-stream drops contents
        push_word(32'h7000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_valid", 32'(bus.decode_valid), 32'd0);
        chk("midrst_ready", 32'(bus.fetch_ready), 32'd1);

`ifdef FETCH_DECODE_BYPASS_EN
        set_word(32'h3000, 1'b1, 5'd0, 3'd3);
        bus.fetch_valid = 1'b1;
        bus.decode_advance = 1'b1;
        #1;
        chk("bypass_valid", 32'(bus.decode_valid), 32'd1);
        chk("bypass_pc", bus.decode_pc, 32'h3000);
        step();
        bus.fetch_valid = 1'b0;
        bus.decode_advance = 1'b0;
        chk("bypass_occ", 32'(occupancy), 32'd0);
        chk("bypass_after_valid", 32'(bus.decode_valid), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
